// File: rtl/screen_sequencer.sv
// Screen sequencer: debounces the three front-panel buttons and steps the
// MENU / PLAY1 / PLAY2 / RESULT screen machine, committing only on frame_start.
module screen_sequencer #(
  parameter int DEB_CYCLES  = 250000,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       btn_menu,
  input  logic       btn_play1,
  input  logic       btn_play2,
  input  logic       frame_start,
  input  logic [1:0] p1_result,
  input  logic [1:0] p2_result,
  output logic [2:0] screen_sel,
  output logic       play_flag,
  output logic       play2_flag,
  output logic       game_rst
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);

  localparam logic [2:0] CODE_MENU  = 3'b000;
  localparam logic [2:0] CODE_PLAY1 = 3'b001;
  localparam logic [2:0] CODE_PLAY2 = 3'b010;
  localparam logic [2:0] CODE_WIN1  = 3'b011;
  localparam logic [2:0] CODE_WIN2  = 3'b100;
  localparam logic [2:0] CODE_LOSE  = 3'b101;

  typedef enum logic [1:0] {
    S_MENU   = 2'd0,
    S_PLAY1  = 2'd1,
    S_PLAY2  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  // Button bit order: [0] menu, [1] play1, [2] play2
  logic [2:0]    btn_raw;
  logic [2:0]    sync_p0;
  logic [2:0]    sync_p1;
  logic [2:0]    deb_p2;
  logic [2:0]    deb_p3;
  logic [DW-1:0] deb_cnt [3];
  logic [2:0]    press;

  assign btn_raw = {btn_play2, btn_play1, btn_menu};

  // Stage p0/p1: two-flop synchronizer; stage p2: debounced level
  always_ff @(posedge clk25) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb_p2  <= '0;
      deb_p3  <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      deb_p3  <= deb_p2;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] != deb_p2[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_p2[i]  <= sync_p1[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Stage p3: press event is the rising edge of the debounced level
  assign press = deb_p2 & ~deb_p3;

  state_t        state;
  state_t        state_n;
  logic          pend_valid;
  logic          pend_valid_n;
  state_t        pend_target;
  state_t        pend_target_n;
  logic [2:0]    pend_code;
  logic [2:0]    pend_code_n;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_n;
  logic          hold_sat;
  logic [2:0]    screen_sel_n;
  logic          play_flag_n;
  logic          play2_flag_n;
  logic          game_rst_n;

  logic          req_valid;
  state_t        req_target;
  logic [2:0]    req_code;
  logic          p1_valid;
  logic          p2_valid;
  logic          result_pending;

  assign hold_sat       = (hold_cnt == HOLD_LAST);
  assign p1_valid       = (p1_result == 2'b01) || (p1_result == 2'b10);
  assign p2_valid       = (p2_result == 2'b10) || (p2_result == 2'b11);
  assign result_pending = pend_valid && (pend_target == S_RESULT);

  always_comb begin
    req_valid     = pend_valid;
    req_target    = pend_target;
    req_code      = pend_code;
    state_n       = state;
    screen_sel_n  = screen_sel;
    play_flag_n   = play_flag;
    play2_flag_n  = play2_flag;
    game_rst_n    = 1'b0;
    hold_cnt_n    = hold_cnt;

    case (state)
      S_MENU: begin
        if (!pend_valid && press[1]) begin
          req_valid  = 1'b1;
          req_target = S_PLAY1;
          req_code   = CODE_PLAY1;
        end else if (!pend_valid && press[2]) begin
          req_valid  = 1'b1;
          req_target = S_PLAY2;
          req_code   = CODE_PLAY2;
        end
      end
      S_PLAY1: begin
        // A game outcome pre-empts an abort that is still waiting for the frame
        if (!result_pending && p1_valid) begin
          req_valid  = 1'b1;
          req_target = S_RESULT;
          req_code   = (p1_result == 2'b01) ? CODE_WIN2 : CODE_WIN1;
        end else if (!pend_valid && press[0]) begin
          req_valid  = 1'b1;
          req_target = S_MENU;
          req_code   = CODE_MENU;
        end
      end
      S_PLAY2: begin
        if (!result_pending && p2_valid) begin
          req_valid  = 1'b1;
          req_target = S_RESULT;
          req_code   = (p2_result == 2'b10) ? CODE_LOSE : CODE_WIN1;
        end else if (!pend_valid && press[0]) begin
          req_valid  = 1'b1;
          req_target = S_MENU;
          req_code   = CODE_MENU;
        end
      end
      S_RESULT: begin
        if (!hold_sat) begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
        if (!pend_valid && hold_sat && (|press)) begin
          req_valid  = 1'b1;
          req_target = S_MENU;
          req_code   = CODE_MENU;
        end
      end
      default: begin
      end
    endcase

    pend_valid_n  = req_valid;
    pend_target_n = req_target;
    pend_code_n   = req_code;

    if (frame_start && req_valid) begin
      state_n       = req_target;
      screen_sel_n  = req_code;
      play_flag_n   = (req_target == S_PLAY1);
      play2_flag_n  = (req_target == S_PLAY2);
      game_rst_n    = (req_target == S_PLAY1) || (req_target == S_PLAY2);
      pend_valid_n  = 1'b0;
      hold_cnt_n    = '0;
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      state       <= S_MENU;
      pend_valid  <= 1'b0;
      pend_target <= S_MENU;
      pend_code   <= CODE_MENU;
      hold_cnt    <= '0;
      screen_sel  <= CODE_MENU;
      play_flag   <= 1'b0;
      play2_flag  <= 1'b0;
      game_rst    <= 1'b0;
    end else begin
      state       <= state_n;
      pend_valid  <= pend_valid_n;
      pend_target <= pend_target_n;
      pend_code   <= pend_code_n;
      hold_cnt    <= hold_cnt_n;
      screen_sel  <= screen_sel_n;
      play_flag   <= play_flag_n;
      play2_flag  <= play2_flag_n;
      game_rst    <= game_rst_n;
    end
  end

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 250000, consecutive stable cycles required to accept a button level change (10 ms at 25 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 25000000, minimum cycles a result screen is shown before exit is allowed (1 s).
REQ-003 SHALL have port clk25  input  1  pixel clock, 25 MHz; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports btn_menu, btn_play1, btn_play2  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-007 SHALL have port p1_result  input  2  single-player outcome: 00 none, 01 player 2 wins, 10 player 1 wins, 11 invalid.
REQ-008 SHALL have port p2_result  input  2  two-player outcome: 00 none, 10 lose, 11 win, 01 invalid.
REQ-009 SHALL have port screen_sel  output  3  000 menu, 001 play1, 010 play2, 011 win1, 100 win2, 101 lose; 110/111 never driven.
REQ-010 SHALL have ports play_flag, play2_flag  output  1 each  high while in PLAY1 / PLAY2 respectively.
REQ-011 SHALL have port game_rst  output  1  one-cycle pulse restarting game datapath.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a debouncer: debounced level takes the synchronized value after DEB_CYCLES consecutive cycles of disagreement; any agreement clears the counter.
REQ-013 A press event SHALL be a one-cycle pulse on the debounced level's rising edge; releases generate nothing.
REQ-014 FSM states SHALL be MENU, PLAY1, PLAY2, RESULT; all outputs registered.
REQ-015 State changes SHALL commit only in a cycle with frame_start=1; requests are latched into a single pending target until then.
REQ-016 While a target is pending, further press events SHALL be ignored, except REQ-019.
REQ-017 MENU: play1 press -> pending PLAY1; play2 press -> pending PLAY2; simultaneous -> PLAY1 wins; menu press ignored.
REQ-018 PLAY1/PLAY2: menu press -> pending MENU (abort); play presses ignored.
REQ-019 PLAY1: p1_result 01 or 10 -> pending RESULT with code 100 or 011 latched that cycle, overriding any pending MENU; 11 ignored. Same-cycle menu press and valid result -> result wins.
REQ-020 PLAY2: p2_result 10 -> pending RESULT code 101; 11 -> code 011; 01 ignored; same override as REQ-019.
REQ-021 RESULT: hold counter SHALL start at 0 on entry, increment per cycle, saturate at HOLD_CYCLES; presses before saturation are discarded, not latched.
REQ-022 RESULT after saturation: any press event -> pending MENU.
REQ-023 Commit SHALL update screen_sel, play_flag, play2_flag in the frame_start cycle's next edge; game_rst SHALL pulse on the same edge only when entering PLAY1 or PLAY2.
REQ-024 frame_start coinciding with a new request SHALL commit that request in the same cycle.
REQ-025 Counters SHALL not wrap; debounce counter width ceil(log2(DEB_CYCLES+1)), hold counter ceil(log2(HOLD_CYCLES+1)).

Reset
REQ-026 With reset=1 at a clock edge: state MENU, screen_sel 000, play_flag 0, play2_flag 0, game_rst 0, pending cleared, all counters 0, synchronizers and debounced levels 0.
REQ-027 Reset SHALL override every other input, including mid-game and mid-RESULT; outputs reach reset values one edge after reset asserts.

Verification (DEB_CYCLES=4, HOLD_CYCLES=16)
REQ-028 btn_play1 held 10 cycles, frame_start 20 cycles later -> screen_sel 001, play_flag 1, single game_rst pulse, on edge after frame_start.
REQ-029 btn_play1 3-cycle glitch -> no state change, no game_rst.
REQ-030 In PLAY1, p1_result=10 and btn_menu press same cycle, then frame_start -> screen_sel 011, no MENU.
REQ-031 In RESULT, press at cycle 5 after entry -> ignored; press at cycle 20 then frame_start -> screen_sel 000.
REQ-032 In MENU, btn_play1 and btn_play2 pressed simultaneously -> PLAY1 entered at next frame_start.
REQ-033 In PLAY2, assert reset one cycle -> next edge screen_sel 000, play2_flag 0, game_rst 0.
